// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-requester Avalon-MM burst arbiter in front of one SDRAM controller port
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed r0 priority; round-robin otherwise.
module sdram_arbiter #(
  parameter int AW = 23,
  parameter int DW = 16,
  parameter int BW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_read,
  input  logic          r1_read,
  input  logic          r0_write,
  input  logic          r1_write,
  input  logic [AW-1:0] r0_address,
  input  logic [AW-1:0] r1_address,
  input  logic [DW-1:0] r0_writedata,
  input  logic [DW-1:0] r1_writedata,
  input  logic [BW-1:0] r0_burstcount,
  input  logic [BW-1:0] r1_burstcount,
  input  logic [1:0]    r0_byteenable,
  input  logic [1:0]    r1_byteenable,
  output logic          r0_waitrequest,
  output logic          r1_waitrequest,
  output logic          r0_readdatavalid,
  output logic          r1_readdatavalid,
  output logic [DW-1:0] r0_readdata,
  output logic [DW-1:0] r1_readdata,
  output logic          m_read,
  output logic          m_write,
  output logic [AW-1:0] m_address,
  output logic [DW-1:0] m_writedata,
  output logic [BW-1:0] m_burstcount,
  output logic [1:0]    m_byteenable,
  input  logic          m_waitrequest,
  input  logic          m_readdatavalid,
  input  logic [DW-1:0] m_readdata,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {IDLE, CMD, RD_WAIT} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [BW-1:0] beats_q, beats_d;
  logic [BW-1:0] len_q, len_d;
  logic [1:0]    grant_q, grant_d;

  logic          req0, req1, in_cmd, own_read, own_write;
  logic          wr_acc, rd_acc, rdv_own;
  logic [BW-1:0] own_bc, burst_len, cur_len, beats_rd;

  assign req0      = r0_read | r0_write;
  assign req1      = r1_read | r1_write;
  assign in_cmd    = (state_q == CMD);
  assign own_read  = owner_q ? r1_read : r0_read;
  assign own_write = owner_q ? r1_write : r0_write;
  assign own_bc    = owner_q ? r1_burstcount : r0_burstcount;
  assign burst_len = (own_bc == '0) ? BW'(1) : own_bc;
  // Before the first write beat is accepted len_q is stale, so use the live burstcount.
  assign cur_len   = (beats_q == '0) ? burst_len : len_q;

  assign m_write      = in_cmd & own_write;
  assign m_read       = in_cmd & own_read & ~own_write;
  assign m_address    = owner_q ? r1_address : r0_address;
  assign m_writedata  = owner_q ? r1_writedata : r0_writedata;
  assign m_burstcount = own_bc;
  assign m_byteenable = owner_q ? r1_byteenable : r0_byteenable;

  assign wr_acc   = m_write & ~m_waitrequest;
  assign rd_acc   = m_read & ~m_waitrequest;
  assign rdv_own  = m_readdatavalid & ((state_q == RD_WAIT) | rd_acc);
  assign beats_rd = beats_q + BW'(rdv_own);

  assign r0_waitrequest   = ~(in_cmd & ~owner_q) | m_waitrequest;
  assign r1_waitrequest   = ~(in_cmd & owner_q) | m_waitrequest;
  assign r0_readdatavalid = rdv_own & ~owner_q;
  assign r1_readdatavalid = rdv_own & owner_q;
  assign r0_readdata      = m_readdata;
  assign r1_readdata      = m_readdata;
  assign grant            = grant_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beats_d = beats_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
          owner_d = ~req0;
`else
          owner_d = (req0 & req1) ? ~last_q : ~req0;
`endif
          last_d  = owner_d;
          beats_d = '0;
          state_d = CMD;
        end
      end
      CMD: begin
        if (wr_acc) begin
          if (beats_q == '0) len_d = burst_len;
          beats_d = beats_q + BW'(1);
          if (beats_q + BW'(1) == cur_len) state_d = IDLE;
        end else if (rd_acc) begin
          len_d   = burst_len;
          beats_d = beats_rd;
          state_d = (beats_rd == burst_len) ? IDLE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        beats_d = beats_rd;
        if (beats_rd == len_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    grant_d = (state_d == IDLE) ? 2'b00 : (owner_d ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      beats_q <= '0;
      len_q   <= '0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      len_q   <= len_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed/randomized bench for sdram_arbiter with SDRAM slave and memory model
// Honours SDRAM_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_sdram_arbiter;
  localparam int AW = 23;
  localparam int DW = 16;
  localparam int BW = 9;

  logic clk = 0, reset = 1;
  logic r0_read = 0, r1_read = 0, r0_write = 0, r1_write = 0;
  logic [AW-1:0] r0_address = '0, r1_address = '0;
  logic [DW-1:0] r0_writedata = '0, r1_writedata = '0;
  logic [BW-1:0] r0_burstcount = '0, r1_burstcount = '0;
  logic [1:0] r0_byteenable = 2'b11, r1_byteenable = 2'b11;
  logic r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid;
  logic [DW-1:0] r0_readdata, r1_readdata;
  logic m_read, m_write;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_writedata;
  logic [BW-1:0] m_burstcount;
  logic [1:0] m_byteenable;
  logic m_waitrequest = 0, m_readdatavalid = 0;
  logic [DW-1:0] m_readdata = '0;
  logic [1:0] grant;

  sdram_arbiter #(.AW(AW), .DW(DW), .BW(BW)) dut (
    .clk(clk), .reset(reset),
    .r0_read(r0_read), .r1_read(r1_read), .r0_write(r0_write), .r1_write(r1_write),
    .r0_address(r0_address), .r1_address(r1_address),
    .r0_writedata(r0_writedata), .r1_writedata(r1_writedata),
    .r0_burstcount(r0_burstcount), .r1_burstcount(r1_burstcount),
    .r0_byteenable(r0_byteenable), .r1_byteenable(r1_byteenable),
    .r0_waitrequest(r0_waitrequest), .r1_waitrequest(r1_waitrequest),
    .r0_readdatavalid(r0_readdatavalid), .r1_readdatavalid(r1_readdatavalid),
    .r0_readdata(r0_readdata), .r1_readdata(r1_readdata),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
    .m_burstcount(m_burstcount), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(int a);
    return DW'(a * 37 + 'h1234);
  endfunction

  logic [DW-1:0] smem [int];
  logic [DW-1:0] ref_mem [int];
  function automatic logic [DW-1:0] smem_rd(int a);
    return smem.exists(a) ? smem[a] : init_val(a);
  endfunction
  function automatic logic [DW-1:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // SDRAM controller model: outputs change just after the edge, acceptance judged mid-cycle.
  bit force_stall = 0, rnd_stall = 0;
  int s_wr_left = 0, s_wr_addr = 0, s_wr_beats = 0;
  logic [DW-1:0] rq[$];
  always begin
    @(posedge clk); #1;
    m_waitrequest = force_stall || (rnd_stall && $urandom_range(0, 3) == 0);
    if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
      m_readdatavalid = 1; m_readdata = rq[0];
    end else begin
      m_readdatavalid = 0; m_readdata = DW'($urandom);
    end
    @(negedge clk);
    if (m_readdatavalid) void'(rq.pop_front());
    if (m_write && !m_waitrequest) begin
      if (s_wr_left == 0) begin
        s_wr_addr = int'(m_address);
        s_wr_left = (m_burstcount == 0) ? 1 : int'(m_burstcount);
      end
      smem[s_wr_addr] = m_writedata;
      s_wr_addr++; s_wr_left--; s_wr_beats++;
    end
    if (m_read && !m_waitrequest)
      for (int k = 0; k < int'(m_burstcount); k++) rq.push_back(smem_rd(int'(m_address) + k));
  end

  logic [DW-1:0] rx0[$], rx1[$];
  logic [1:0] glog[$];
  int gcyc[$];
  logic [1:0] prev_grant = 2'b00;
  always @(negedge clk) begin
    if (r0_readdatavalid || r1_readdatavalid)
      chk("rdv_owner", int'({r1_readdatavalid, r0_readdatavalid} & ~grant), 0);
    if (r0_readdatavalid) rx0.push_back(r0_readdata);
    if (r1_readdatavalid) rx1.push_back(r1_readdata);
    if (grant != prev_grant && grant != 2'b00) begin
      glog.push_back(grant); gcyc.push_back(cyc);
    end
    prev_grant <= grant;
  end

  function automatic int rxsz(int p);
    return (p == 0) ? rx0.size() : rx1.size();
  endfunction
  function automatic int rxat(int p, int i);
    if (i >= rxsz(p)) return -1;
    return (p == 0) ? int'(rx0[i]) : int'(rx1[i]);
  endfunction
  function automatic logic wreq(int p);
    return (p == 0) ? r0_waitrequest : r1_waitrequest;
  endfunction

  task automatic drive(int p, logic rd, logic wr, int a, int bc, logic [DW-1:0] d);
    if (p == 0) begin
      r0_read = rd; r0_write = wr; r0_address = AW'(a); r0_burstcount = BW'(bc); r0_writedata = d;
    end else begin
      r1_read = rd; r1_write = wr; r1_address = AW'(a); r1_burstcount = BW'(bc); r1_writedata = d;
    end
  endtask

  // Call just after a rising edge; returns just after a rising edge.
  task automatic do_write(int p, int a, int n, int drop_at, int drop_len, bit seq);
    logic [DW-1:0] d[$];
    int i = 0, dropped = 0, t = 0;
    logic on = 1, acc;
    for (int k = 0; k < n; k++) d.push_back(seq ? DW'(k + 1) : DW'($urandom));
    drive(p, 0, 1, a, n, d[0]);
    while (i < n && t < 5000) begin
      @(negedge clk); acc = on && !wreq(p);
      @(posedge clk); #1; t++;
      if (acc) begin ref_mem[a + i] = d[i]; i++; end
      if (i == drop_at && dropped < drop_len) begin on = 0; dropped++; end
      else on = 1;
      if (i < n) drive(p, 0, on, a, n, d[i]);
      else drive(p, 0, 0, a, n, '0);
    end
    chk("wr_done", i, n);
  endtask

  task automatic do_read(int p, int a, int n);
    int t = 0, start = rxsz(p);
    logic acc;
    drive(p, 1, 0, a, n, '0);
    do begin
      @(negedge clk); acc = !wreq(p);
      @(posedge clk); #1; t++;
    end while (!acc && t < 3000);
    drive(p, 0, 0, a, n, '0);
    chk("rd_accept", int'(acc), 1);
    while (rxsz(p) < start + n && t < 3000) begin @(posedge clk); #1; t++; end
    chk("rd_count", rxsz(p) - start, n);
    for (int k = 0; k < n; k++) chk("rd_data", rxat(p, start + k), int'(ref_rd(a + k)));
  endtask

  task automatic chk_glog(string tag, logic [5:0] eord, int n);
    chk(tag, glog.size(), n);
    for (int i = 0; i < n; i++)
      chk(tag, (i < glog.size()) ? int'(glog[i]) : -1, int'(eord[2*i +: 2]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cyc, b0, gw, nw, t, rxs, a0, a1, c0;
    logic [5:0] eord;
    repeat (3) @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_wait", int'({r1_waitrequest, r0_waitrequest}), 3);
    chk("rst_rdv", int'({r1_readdatavalid, r0_readdatavalid}), 0);
    chk("rst_mcmd", int'({m_read, m_write}), 0);
    reset = 0;
    @(posedge clk); #1;

    // single r0 write burst, data 1..4
    req_cyc = cyc;
    do_write(0, 'h100, 4, -1, 0, 1);
    chk("t1_grant_idle", int'(grant), 0);
    chk("t1_latency", (gcyc.size() > 0) ? gcyc[0] - req_cyc : -1, 1);
    chk_glog("t1_glog", 6'b000001, 1);
    chk("t1_beats", s_wr_beats, 4);
    for (int i = 0; i < 4; i++) chk("t1_mem", int'(smem_rd('h100 + i)), i + 1);

    // r1 read over the freshly written words and beyond
    glog.delete(); gcyc.delete();
    do_read(1, 'h100, 8);
    chk("t2_r0_rdv", rx0.size(), 0);
    chk_glog("t2_glog", 6'b000010, 1);

    // contention: r0 re-requests in its final beat cycle
    glog.delete(); gcyc.delete();
    a0 = 'h2000 + 16 * $urandom_range(0, 255);
    a1 = 'h6000 + 16 * $urandom_range(0, 255);
    c0 = 'h4000 + 16 * $urandom_range(0, 255);
    fork
      begin do_write(0, a0, 2, -1, 0, 0); do_write(0, a1, 2, -1, 0, 0); end
      do_read(1, c0, 4);
    join
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    eord = {2'b10, 2'b01, 2'b01};
`else
    eord = {2'b01, 2'b10, 2'b01};
`endif
    chk_glog("t3_glog", eord, 3);
    chk("t3_mem", int'(smem_rd(a1 + 1)), int'(ref_rd(a1 + 1)));

    // 256-beat write with a 10-cycle gap while r1 waits to read its tail
    glog.delete(); gcyc.delete();
    rnd_stall = 1;
    b0 = s_wr_beats;
    fork
      do_write(0, 'h8000, 256, 100, 10, 0);
      begin repeat (5) @(posedge clk); #1; do_read(1, 'h8000 + 250, 4); end
    join
    rnd_stall = 0;
    chk_glog("t4_glog", 6'b001001, 2);
    chk("t4_beats", s_wr_beats - b0, 256);

    // controller stalls 20 cycles on grant
    glog.delete(); gcyc.delete();
    force_stall = 1;
    @(posedge clk); #1;
    b0 = s_wr_beats;
    fork
      do_write(0, 'h300, 2, -1, 0, 0);
      begin
        gw = 0;
        while (grant != 2'b01 && gw < 10) begin @(negedge clk); gw++; end
        chk("t5_grant", int'(grant), 1);
        nw = 0;
        repeat (20) begin
          if (r0_waitrequest) nw++;
          @(negedge clk);
        end
        chk("t5_wait_cycles", nw, 20);
        chk("t5_no_beats", s_wr_beats - b0, 0);
        force_stall = 0;
      end
    join
    chk("t5_beats", s_wr_beats - b0, 2);

    // reset in the middle of an 8-beat read
    rxs = rx0.size();
    drive(0, 1, 0, 'h100, 8, '0);
    t = 0;
    do begin
      @(negedge clk); gw = int'(!r0_waitrequest);
      @(posedge clk); #1; t++;
    end while (gw == 0 && t < 100);
    drive(0, 0, 0, 'h100, 8, '0);
    t = 0;
    while (rx0.size() < rxs + 3 && t < 200) begin @(posedge clk); #1; t++; end
    chk("t6_three_beats", rx0.size(), rxs + 3);
    #2 reset = 1;
    #1;
    chk("t6_grant", int'(grant), 0);
    chk("t6_wait", int'({r1_waitrequest, r0_waitrequest}), 3);
    chk("t6_rdv", int'({r1_readdatavalid, r0_readdatavalid}), 0);
    repeat (2) @(negedge clk);
    reset = 0;
    t = 0;
    while (rq.size() > 0 && t < 100) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    chk("t6_dropped", rx0.size(), rxs + 3);
    glog.delete(); gcyc.delete();
    @(posedge clk); #1;
    do_read(1, 'h8000, 4);
    chk_glog("t6_glog", 6'b000010, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
